// File: rtl/uart_operand_sequencer_pkg.sv
// rtl/uart_operand_sequencer_pkg.sv - shared constants for the UART operand sequencer (package uart_seq_pkg)
package uart_seq_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0018;

  // Word select within the register block, i.e. byte offset [3:2].
  typedef enum logic [1:0] {
    REG_OPA    = 2'd0,
    REG_OPB    = 2'd1,
    REG_RESULT = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_t;

  localparam logic [3:0] OFF_OPA    = 4'h0;
  localparam logic [3:0] OFF_OPB    = 4'h4;
  localparam logic [3:0] OFF_RESULT = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int STAT_READY   = 0;
  localparam int STAT_TX_BUSY = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_IRQ_EN  = 3;

  localparam logic [1:0] ST_WAIT_A = 2'd0;
  localparam logic [1:0] ST_WAIT_B = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_SEND   = 2'd3;

endpackage

// File: rtl/uart_operand_sequencer_if.sv
// rtl/uart_operand_sequencer_if.sv - UART core and CPU data-bus signals of the operand sequencer
interface uart_operand_sequencer_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [31:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;

  modport master (
    output rx_data, rx_valid, tx_busy, bus_addr, bus_rd, bus_wr, bus_wdata,
    input  tx_data, tx_start, bus_rdata, irq
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy, bus_addr, bus_rd, bus_wr, bus_wdata,
    output tx_data, tx_start, bus_rdata, irq
  );

endinterface

// File: rtl/uart_operand_sequencer_regs.sv
// rtl/uart_operand_sequencer_regs.sv - address decode, STATUS storage and read mux (module uart_seq_regs)
module uart_seq_regs
  import uart_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_bus_addr,
  input  logic        i_bus_rd,
  input  logic        i_bus_wr,
  input  logic [3:2]  i_status_wdata,
  input  logic [7:0]  i_opa,
  input  logic [7:0]  i_opb,
  input  logic        i_ready,
  input  logic        i_tx_busy,
  input  logic        i_overrun_set,
  output logic [31:0] o_bus_rdata,
  output logic        o_irq,
  output logic        o_result_wr
);

  logic [31:0] w_off;
  logic        w_hit;
  reg_sel_t    w_sel;
  logic        w_status_wr;
  logic        r_overrun;
  logic        r_irq_en;

  // BASE_ADDR is only word aligned, so decode on the offset rather than on high address bits.
  assign w_off       = i_bus_addr - BASE_ADDR;
  assign w_hit       = (w_off[31:4] == 28'd0) && (w_off[1:0] == 2'b00);
  assign w_sel       = reg_sel_t'(w_off[3:2]);
  assign o_result_wr = i_bus_wr && w_hit && (w_sel == REG_RESULT);
  assign w_status_wr = i_bus_wr && w_hit && (w_sel == REG_STATUS);
  assign o_irq       = i_ready & r_irq_en;

  // STATUS storage: irq_en is plain RW, overrun is sticky W1C with a new event beating the clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (w_status_wr) begin
        r_irq_en <= i_status_wdata[STAT_IRQ_EN];
      end
      if (i_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (w_status_wr && i_status_wdata[STAT_OVERRUN]) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Read mux: zero outside the block, when not reading, and for the write-only RESULT word.
  always_comb begin
    o_bus_rdata = 32'd0;
    if (i_bus_rd && w_hit) begin
      case (w_sel)
        REG_OPA:    o_bus_rdata = {24'd0, i_opa};
        REG_OPB:    o_bus_rdata = {24'd0, i_opb};
        REG_STATUS: o_bus_rdata = {28'd0, r_irq_en, r_overrun, i_tx_busy, i_ready};
        default:    o_bus_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: rtl/uart_operand_sequencer.sv
// rtl/uart_operand_sequencer.sv - UART operand/result sequencer top; UART_ECHO_EN adds operand echo
module uart_operand_sequencer
  import uart_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  uart_operand_sequencer_if.slave  bus
);

  logic [1:0] r_state;
  logic [7:0] r_opa;
  logic [7:0] r_opb;
  logic [7:0] r_result;
  logic       w_rx_accept;
  logic       w_overrun_set;
  logic       w_ready;
  logic       w_result_wr;
  logic       w_result_sent;
  logic       w_irq;
  logic [31:0] w_rdata;
  logic       w_unused;

  assign w_rx_accept   = bus.rx_valid && ((r_state == ST_WAIT_A) || (r_state == ST_WAIT_B));
  assign w_overrun_set = bus.rx_valid && ((r_state == ST_READY) || (r_state == ST_SEND));
  assign w_ready       = (r_state == ST_READY);
  assign w_unused      = &{1'b0, bus.bus_wdata[31:8], bus.bus_wdata[1:0]};

  uart_seq_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_bus_addr     (bus.bus_addr),
    .i_bus_rd       (bus.bus_rd),
    .i_bus_wr       (bus.bus_wr),
    .i_status_wdata (bus.bus_wdata[3:2]),
    .i_opa          (r_opa),
    .i_opb          (r_opb),
    .i_ready        (w_ready),
    .i_tx_busy      (bus.tx_busy),
    .i_overrun_set  (w_overrun_set),
    .o_bus_rdata    (w_rdata),
    .o_irq          (w_irq),
    .o_result_wr    (w_result_wr)
  );

  assign bus.bus_rdata = w_rdata;
  assign bus.irq       = w_irq;

`ifdef UART_ECHO_EN
  logic       r_echo_valid;
  logic [7:0] r_echo_data;
  logic       r_tx_start_q;
  logic       w_tx_free;
  logic       w_echo_fire;

  // The start-pulse history keeps an echo and a result from going out on adjacent cycles.
  assign w_tx_free     = !bus.tx_busy && !r_tx_start_q;
  assign w_echo_fire   = r_echo_valid && w_tx_free;
  assign w_result_sent = (r_state == ST_SEND) && w_tx_free && !r_echo_valid;
  assign bus.tx_start  = w_echo_fire || w_result_sent;
  assign bus.tx_data   = r_echo_valid ? r_echo_data : r_result;

  // Single-entry echo buffer; a slot freed by this cycle's send can take the incoming byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_echo_valid <= 1'b0;
      r_echo_data  <= 8'd0;
      r_tx_start_q <= 1'b0;
    end else begin
      r_tx_start_q <= bus.tx_start;
      if (w_rx_accept && (!r_echo_valid || w_echo_fire)) begin
        r_echo_valid <= 1'b1;
        r_echo_data  <= bus.rx_data;
      end else if (w_echo_fire) begin
        r_echo_valid <= 1'b0;
      end
    end
  end
`else
  // The result goes out in the same cycle the transmitter is seen idle.
  assign w_result_sent = (r_state == ST_SEND) && !bus.tx_busy;
  assign bus.tx_start  = w_result_sent;
  assign bus.tx_data   = r_result;
`endif

  // Transaction FSM: two operands in, wait for the CPU result, hand it to the transmitter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_WAIT_A;
      r_opa    <= 8'd0;
      r_opb    <= 8'd0;
      r_result <= 8'd0;
    end else begin
      case (r_state)
        ST_WAIT_A: begin
          if (bus.rx_valid) begin
            r_opa   <= bus.rx_data;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (bus.rx_valid) begin
            r_opb   <= bus.rx_data;
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (w_result_wr) begin
            r_result <= bus.bus_wdata[7:0];
            r_state  <= ST_SEND;
          end
        end
        default: begin
          if (w_result_sent) begin
            r_state <= ST_WAIT_A;
          end
        end
      endcase
    end
  end

endmodule
